ebi_master: RTL and testbench

//  Initiator side of the PPC external bus interface (EBI): turns a simple valid/ready request into a

---
 rtl/ebi_master_pkg.sv | 27 ++
 rtl/ebi_master.sv | 191 +++++++++++++++++++
 tb/tb_ebi_master.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebi_master_pkg.sv
// Shared EBI definitions: bus widths, default cycle timing, FSM states and the counter reload helper.
package ebi_master_pkg;

  localparam int unsigned EBI_ADDR_W = 24;
  localparam int unsigned EBI_DATA_W = 32;
  localparam int unsigned EBI_BE_W   = EBI_DATA_W / 8;
  localparam int unsigned CNT_W      = 8;

  localparam int unsigned DEF_SETUP_CYC  = 1;
  localparam int unsigned DEF_STROBE_CYC = 3;
  localparam int unsigned DEF_HOLD_CYC   = 1;
  localparam int unsigned DEF_TURN_CYC   = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_TURN
  } ebi_state_e;

  // The counter holds "cycles remaining minus one" so a state exits when it reads zero.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/ebi_master.sv
// EBI initiator: converts a valid/ready request into a registered cs_n/oe_n/we_n/rd_wr bus cycle.
module ebi_master
  import ebi_master_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned TURN_CYC   = DEF_TURN_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [EBI_ADDR_W-1:0] req_addr,
  input  logic [EBI_DATA_W-1:0] req_wdata,
  input  logic [EBI_BE_W-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [EBI_DATA_W-1:0] rsp_rdata,
  output logic                  cs_n,
  output logic                  oe_n,
  output logic [EBI_BE_W-1:0]   we_n,
  output logic                  rd_wr,
  output logic [EBI_ADDR_W-1:0] ebi_addr,
  output logic [EBI_DATA_W-1:0] ebi_data_o,
  output logic                  ebi_data_oe,
  input  logic [EBI_DATA_W-1:0] ebi_data_i
);

  ebi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [EBI_BE_W-1:0]   be_q, be_d;
  logic [EBI_DATA_W-1:0] cap_q, cap_d;
  logic [EBI_DATA_W-1:0] rdata_q, rdata_d;
  logic                  rsp_q, rsp_d;
  logic                  rsp_wr_q, rsp_wr_d;
  logic                  cs_n_q, cs_n_d;
  logic                  oe_n_q, oe_n_d;
  logic [EBI_BE_W-1:0]   we_n_q, we_n_d;
  logic                  rd_wr_q, rd_wr_d;
  logic [EBI_ADDR_W-1:0] addr_q, addr_d;
  logic [EBI_DATA_W-1:0] dout_q, dout_d;
  logic                  doe_q, doe_d;
  logic                  done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      cap_q    <= '0;
      rdata_q  <= '0;
      rsp_q    <= 1'b0;
      rsp_wr_q <= 1'b0;
      cs_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= '1;
      rd_wr_q  <= 1'b1;
      addr_q   <= '0;
      dout_q   <= '0;
      doe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      be_q     <= be_d;
      cap_q    <= cap_d;
      rdata_q  <= rdata_d;
      rsp_q    <= rsp_d;
      rsp_wr_q <= rsp_wr_d;
      cs_n_q   <= cs_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      rd_wr_q  <= rd_wr_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      doe_q    <= doe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    be_d     = be_q;
    cap_d    = cap_q;
    rdata_d  = rdata_q;
    rsp_d    = 1'b0;
    rsp_wr_d = rsp_wr_q;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_SETUP;
          cnt_d   = cnt_load(SETUP_CYC);
          wr_d    = req_wr;
          be_d    = req_be;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = cnt_load(STROBE_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          if (!wr_q) cap_d = ebi_data_i;
          if (HOLD_CYC != 0) begin
            state_d = S_HOLD;
            cnt_d   = cnt_load(HOLD_CYC);
          end else begin
            done = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) done = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      S_TURN: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // With no HOLD phase the completion edge is also the capture edge, so bypass cap_q.
    if (done) begin
      rsp_d    = 1'b1;
      rsp_wr_d = wr_q;
      if (!wr_q) rdata_d = (HOLD_CYC == 0) ? ebi_data_i : cap_q;
      state_d  = (TURN_CYC != 0) ? S_TURN : S_IDLE;
      cnt_d    = cnt_load(TURN_CYC);
    end

    // Pad registers are loaded from the state being entered so they line up with it.
    cs_n_d  = cs_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    rd_wr_d = rd_wr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    doe_d   = doe_q;
    case (state_d)
      S_SETUP: begin
        if (state_q == S_IDLE) begin
          cs_n_d  = 1'b0;
          rd_wr_d = ~req_wr;
          addr_d  = req_addr;
          doe_d   = req_wr;
          if (req_wr) dout_d = req_wdata;
        end
      end
      S_STROBE: begin
        oe_n_d = wr_q;
        we_n_d = wr_q ? ~be_q : '1;
      end
      S_HOLD: begin
        oe_n_d = 1'b1;
        we_n_d = '1;
      end
      default: begin
        cs_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = '1;
        rd_wr_d = 1'b1;
        doe_d   = 1'b0;
      end
    endcase
  end

  assign req_ready   = rst_n && (state_q == S_IDLE);
  assign rsp_valid   = rsp_q;
  assign rsp_rdata   = (rsp_q && rsp_wr_q) ? '0 : rdata_q;
  assign cs_n        = cs_n_q;
  assign oe_n        = oe_n_q;
  assign we_n        = we_n_q;
  assign rd_wr       = rd_wr_q;
  assign ebi_addr    = addr_q;
  assign ebi_data_o  = dout_q;
  assign ebi_data_oe = doe_q;

endmodule

// File: tb/tb_ebi_master.sv
// Scoreboard bench for ebi_master: default-timing DUT (0) and fast-timing DUT (1), each with a 4-word slave.
module tb_ebi_master;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          cs;
    int          oe;
    int          we;
    logic [3:0]  wepat;
    int          doe;
    int          hs_gap;
    int          cs_gap;
    logic        chk_mem;
    logic [1:0]  midx;
    logic [31:0] memval;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wr [2];
  logic [23:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        cs_n [2];
  logic        oe_n [2];
  logic [3:0]  we_n [2];
  logic        rd_wr [2];
  logic [23:0] ebi_addr [2];
  logic [31:0] ebi_data_o [2];
  logic        ebi_data_oe [2];
  logic [31:0] ebi_data_i [2];
  logic [31:0] mem [2][4];

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   tmo_cnt = 0;
  logic done = 1'b0;

  always #5 clk = ~clk;

  ebi_master u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wr(req_wr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .cs_n(cs_n[0]), .oe_n(oe_n[0]),
    .we_n(we_n[0]), .rd_wr(rd_wr[0]), .ebi_addr(ebi_addr[0]), .ebi_data_o(ebi_data_o[0]),
    .ebi_data_oe(ebi_data_oe[0]), .ebi_data_i(ebi_data_i[0])
  );

  ebi_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(0), .TURN_CYC(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wr(req_wr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .cs_n(cs_n[1]), .oe_n(oe_n[1]),
    .we_n(we_n[1]), .rd_wr(rd_wr[1]), .ebi_addr(ebi_addr[1]), .ebi_data_o(ebi_data_o[1]),
    .ebi_data_oe(ebi_data_oe[1]), .ebi_data_i(ebi_data_i[1])
  );

  // Behavioural slave: drives read data while selected and output-enabled, byte-writes on low we_n.
  assign ebi_data_i[0] = (!cs_n[0] && !oe_n[0]) ? mem[0][ebi_addr[0][1:0]] : 32'hBAD0BAD0;
  assign ebi_data_i[1] = (!cs_n[1] && !oe_n[1]) ? mem[1][ebi_addr[1][1:0]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 4; b++)
        if (!cs_n[d] && !we_n[d][b])
          mem[d][ebi_addr[d][1:0]][8*b +: 8] <= ebi_data_o[d][8*b +: 8];
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%h exp=%h", nm, d, act, exp);
    end
  endtask

  // Monitor: pad-activity counters per access, reset checks, scoreboard pops on rsp_valid.
  int   cyc = 0;
  int   hs_cyc [2];
  int   hs_gap_m [2];
  int   cs_cnt [2];
  int   oe_cnt [2];
  int   we_cnt [2];
  int   doe_cnt [2];
  int   cs_hi_run [2];
  int   cs_gap_m [2];
  logic [3:0] wepat [2];
  logic rst_prev = 1'b1;

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        if (!rst_prev) begin
          chk("rst_cs_n", d, 32'(cs_n[d]), 32'd1);
          chk("rst_oe_n", d, 32'(oe_n[d]), 32'd1);
          chk("rst_we_n", d, 32'(we_n[d]), 32'hF);
          chk("rst_data_oe", d, 32'(ebi_data_oe[d]), 32'd0);
          chk("rst_req_ready", d, 32'(req_ready[d]), 32'd0);
          chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
        end
        hs_cyc[d] = cyc; hs_gap_m[d] = 0; cs_cnt[d] = 0; oe_cnt[d] = 0; we_cnt[d] = 0;
        doe_cnt[d] = 0; cs_hi_run[d] = 0; cs_gap_m[d] = 0; wepat[d] = '0;
      end else begin
        if (!rst_prev) begin
          chk("post_rst_ready", d, 32'(req_ready[d]), 32'd1);
          chk("post_rst_rdata", d, rsp_rdata[d], 32'd0);
          chk("post_rst_addr", d, 32'(ebi_addr[d]), 32'd0);
          chk("post_rst_rd_wr", d, 32'(rd_wr[d]), 32'd1);
        end
        if (!oe_n[d]) chk("oe_vs_data_oe", d, 32'(ebi_data_oe[d]), 32'd0);
        if (cs_n[d]) cs_hi_run[d]++;
        else begin
          if (cs_hi_run[d] != 0) cs_gap_m[d] = cs_hi_run[d];
          cs_hi_run[d] = 0;
          cs_cnt[d]++;
        end
        if (!oe_n[d]) oe_cnt[d]++;
        if (we_n[d] != 4'hF) we_cnt[d]++;
        if (ebi_data_oe[d]) doe_cnt[d]++;
        wepat[d] |= ~we_n[d];
        if (req_valid[d] && req_ready[d]) begin
          hs_gap_m[d] = cyc - hs_cyc[d];
          hs_cyc[d] = cyc;
          cs_cnt[d] = 0; oe_cnt[d] = 0; we_cnt[d] = 0; doe_cnt[d] = 0; wepat[d] = '0;
        end
        if (rsp_valid[d]) begin
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp dut%0d got=rsp_valid exp=none", d);
          end else begin
            exp_t e;
            e = expq.pop_front();
            chk("rsp_rdata", d, rsp_rdata[d], e.rdata);
            chk("latency", d, 32'(cyc - hs_cyc[d]), 32'(e.lat));
            chk("cs_low_cycles", d, 32'(cs_cnt[d]), 32'(e.cs));
            chk("oe_low_cycles", d, 32'(oe_cnt[d]), 32'(e.oe));
            chk("we_low_cycles", d, 32'(we_cnt[d]), 32'(e.we));
            chk("we_pattern", d, 32'(wepat[d]), 32'(e.wepat));
            chk("data_oe_cycles", d, 32'(doe_cnt[d]), 32'(e.doe));
            if (e.hs_gap != 0) chk("handshake_gap", d, 32'(hs_gap_m[d]), 32'(e.hs_gap));
            if (e.cs_gap != 0) chk("cs_high_gap", d, 32'(cs_gap_m[d]), 32'(e.cs_gap));
            if (e.chk_mem) chk("slave_mem", d, mem[d][e.midx], e.memval);
          end
        end
      end
    end
    rst_prev = rst_n;
    if (done) begin
      chk("timeouts", 0, 32'(tmo_cnt), 32'd0);
      chk("pending_rsp", 0, 32'(expq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  function automatic exp_t mk(logic [31:0] rdata, int lat, int cs, int oe, int we, logic [3:0] wp,
                              int doe, int hsg, int csg, logic cm, logic [1:0] mi, logic [31:0] mv);
    exp_t e;
    e.rdata = rdata; e.lat = lat; e.cs = cs; e.oe = oe; e.we = we; e.wepat = wp; e.doe = doe;
    e.hs_gap = hsg; e.cs_gap = csg; e.chk_mem = cm; e.midx = mi; e.memval = mv;
    return e;
  endfunction

  task automatic issue(input int d, input logic wr, input logic [23:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic keep);
    int n;
    n = 0;
    req_wr[d] = wr; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be; req_valid[d] = 1'b1;
    while (1) begin
      @(negedge clk);
      if (req_ready[d]) break;
      n++;
      if (n > 50) begin
        tmo_cnt++;
        $display("FAIL handshake_timeout dut%0d got=no_ready exp=ready", d);
        break;
      end
    end
    @(posedge clk); #1;
    if (!keep) req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (expq.size() != 0) begin
      tmo_cnt++;
      $display("FAIL drain_timeout got=%0d exp=0", expq.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-STROBE of a write: no response may appear.
    issue(0, 1'b1, 24'h000001, 32'h11111111, 4'hF, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Default timing: write, read back, byte write, read back.
    expq.push_back(mk(32'h0, 6, 5, 0, 3, 4'hF, 5, 0, 0, 1'b1, 2'd0, 32'hDEADBEEF));
    issue(0, 1'b1, 24'h000010, 32'hDEADBEEF, 4'hF, 1'b0);
    drain();
    expq.push_back(mk(32'hDEADBEEF, 6, 5, 3, 0, 4'h0, 0, 0, 0, 1'b0, 2'd0, 32'h0));
    issue(0, 1'b0, 24'h000010, 32'h0, 4'hF, 1'b0);
    drain();
    expq.push_back(mk(32'h0, 6, 5, 0, 3, 4'b0010, 5, 0, 0, 1'b1, 2'd0, 32'hDEADAAEF));
    issue(0, 1'b1, 24'h000010, 32'h0000AA00, 4'b0010, 1'b0);
    drain();
    expq.push_back(mk(32'hDEADAAEF, 6, 5, 3, 0, 4'h0, 0, 0, 0, 1'b0, 2'd0, 32'h0));
    issue(0, 1'b0, 24'h000010, 32'h0, 4'hF, 1'b0);
    drain();

    // Back-to-back with req_valid held: read then write.
    expq.push_back(mk(32'h0, 6, 5, 0, 3, 4'hF, 5, 0, 0, 1'b1, 2'd1, 32'h12345678));
    issue(0, 1'b1, 24'h000011, 32'h12345678, 4'hF, 1'b0);
    drain();
    expq.push_back(mk(32'h12345678, 6, 5, 3, 0, 4'h0, 0, 0, 0, 1'b0, 2'd0, 32'h0));
    expq.push_back(mk(32'h0, 6, 5, 0, 3, 4'hF, 5, 7, 2, 1'b1, 2'd2, 32'hCAFEF00D));
    issue(0, 1'b0, 24'h000011, 32'h0, 4'hF, 1'b1);
    issue(0, 1'b1, 24'h000012, 32'hCAFEF00D, 4'hF, 1'b0);
    drain();

    // Fast timing DUT: SETUP=2 STROBE=1 HOLD=0 TURN=0.
    expq.push_back(mk(32'h0, 4, 3, 0, 1, 4'hF, 3, 0, 0, 1'b1, 2'd0, 32'h0BADF00D));
    issue(1, 1'b1, 24'h000020, 32'h0BADF00D, 4'hF, 1'b0);
    drain();
    expq.push_back(mk(32'h0BADF00D, 4, 3, 1, 0, 4'h0, 0, 0, 0, 1'b0, 2'd0, 32'h0));
    issue(1, 1'b0, 24'h000020, 32'h0, 4'hF, 1'b0);
    drain();
    expq.push_back(mk(32'h0, 4, 3, 0, 0, 4'h0, 3, 0, 0, 1'b1, 2'd0, 32'h0BADF00D));
    issue(1, 1'b1, 24'h000020, 32'hFFFFFFFF, 4'h0, 1'b0);
    drain();
    expq.push_back(mk(32'h0BADF00D, 4, 3, 1, 0, 4'h0, 0, 0, 0, 1'b0, 2'd0, 32'h0));
    issue(1, 1'b0, 24'h000020, 32'h0, 4'hF, 1'b0);
    drain();

    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
